enc8to3_seq: RTL and testbench

ENC8TO3_SEQ -- requirements
Module: enc8to3_seq

---
 rtl/enc_pkg.sv | 11 +
 rtl/pri_enc8.sv | 28 ++
 rtl/enc8to3_seq.sv | 115 +++++++++++
 tb/tb_enc8to3_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared widths and FSM state type for the sequential 8-to-3 encoder.
// ENC_RR_EN (defined by the build) selects round-robin instead of fixed priority.
package enc_pkg;
    localparam int IN_W   = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        IDLE,
        SERVE
    } state_t;
endpackage

// File: rtl/pri_enc8.sv
// Circular priority encoder: the first set bit at or after start wins.
// With start tied to zero this is plain lowest-index priority.
module pri_enc8
    import enc_pkg::*;
(
    input  logic [IN_W-1:0]   vec,
    input  logic [CODE_W-1:0] start,
    output logic              found,
    output logic [CODE_W-1:0] index
);

    logic [CODE_W-1:0] pos;

    // Scan from the farthest offset down so the nearest hit is the last write
    always_comb begin
        found = 1'b0;
        index = '0;
        pos   = '0;
        for (int i = IN_W - 1; i >= 0; i--) begin
            pos = start + CODE_W'(i);
            if (vec[pos]) begin
                found = 1'b1;
                index = pos;
            end
        end
    end

endmodule

// File: rtl/enc8to3_seq.sv
// Sequential multi-hot request encoder: serves one pending index per accept.
// Define ENC_RR_EN for round-robin selection; default is lowest index first.
module enc8to3_seq
    import enc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   req,
    input  logic              load,
    input  logic              out_ready,
    output logic [CODE_W-1:0] code,
    output logic              out_valid,
    output logic              busy,
    output logic              zero
);

    state_t            state;
    state_t            state_n;
    logic [IN_W-1:0]   pend;
    logic [IN_W-1:0]   pend_n;
    logic [IN_W-1:0]   served_mask;
    logic [IN_W-1:0]   merge;
    logic [IN_W-1:0]   vec;
    logic [CODE_W-1:0] code_n;
    logic [CODE_W-1:0] start;
    logic [CODE_W-1:0] sel;
    logic              valid_n;
    logic              zero_n;
    logic              found;
    logic              accept;

    assign accept      = (state == SERVE) && out_ready;
    assign served_mask = accept ? (IN_W'(1) << code) : '0;
    assign merge       = load ? req : '0;
    // Selection only sees the post-accept, post-merge pending set
    assign vec = (state == IDLE) ? req
                                 : ((pend & ~served_mask) | merge);

`ifdef ENC_RR_EN
    logic [CODE_W-1:0] ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= code + CODE_W'(1);
        end
    end

    assign start = accept ? (code + CODE_W'(1)) : ptr;
`else
    assign start = '0;
`endif

    pri_enc8 u_pri (
        .vec   (vec),
        .start (start),
        .found (found),
        .index (sel)
    );

    always_comb begin
        state_n = state;
        pend_n  = pend;
        code_n  = code;
        valid_n = 1'b0;
        zero_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (load) begin
                    if (found) begin
                        state_n = SERVE;
                        pend_n  = vec;
                        code_n  = sel;
                        valid_n = 1'b1;
                    end else begin
                        zero_n = 1'b1;
                    end
                end
            end
            SERVE: begin
                pend_n  = vec;
                valid_n = 1'b1;
                if (accept) begin
                    if (found) begin
                        code_n = sel;
                    end else begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= '0;
            code      <= '0;
            out_valid <= 1'b0;
            zero      <= 1'b0;
        end else begin
            state     <= state_n;
            pend      <= pend_n;
            code      <= code_n;
            out_valid <= valid_n;
            zero      <= zero_n;
        end
    end

    assign busy = (state == SERVE);

endmodule

// File: tb/tb_enc8to3_seq.sv
// Self-checking bench: directed scenarios plus random traffic against
// a pending-set reference model (follows ENC_RR_EN if defined).
module tb_enc8to3_seq;
    import enc_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [IN_W-1:0]   req;
    logic              load;
    logic              out_ready;
    logic [CODE_W-1:0] code;
    logic              out_valid;
    logic              busy;
    logic              zero;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: pending set, presented code, round-robin pointer
    bit [7:0] m_pend;
    int       m_code;
    bit       m_valid;
    bit       m_zero;
    int       m_ptr;

    always #5 clk = ~clk;

    enc8to3_seq dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .load      (load),
        .out_ready (out_ready),
        .code      (code),
        .out_valid (out_valid),
        .busy      (busy),
        .zero      (zero)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int pick(bit [7:0] p, int from);
        for (int k = 0; k < 8; k++)
            if (p[(from + k) % 8]) return (from + k) % 8;
        return -1;
    endfunction

    function automatic int first_at();
`ifdef ENC_RR_EN
        return m_ptr;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_code  = 0;
        m_valid = 1'b0;
        m_zero  = 1'b0;
        m_ptr   = 0;
    endtask

    task automatic model_step(bit [7:0] r, bit l, bit rdy);
        m_zero = 1'b0;
        if (!m_valid) begin
            if (l && r == 0) begin
                m_zero = 1'b1;
            end else if (l) begin
                m_pend  = r;
                m_code  = pick(m_pend, first_at());
                m_valid = 1'b1;
            end
        end else if (rdy) begin
            m_pend[m_code] = 1'b0;
            m_ptr = (m_code + 1) % 8;
            if (l) m_pend |= r;
            if (m_pend == 0) m_valid = 1'b0;
            else m_code = pick(m_pend, first_at());
        end else if (l) begin
            m_pend |= r;
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, "_busy"}, 32'(busy), 32'(m_valid));
        chk({tag, "_zero"}, 32'(zero), 32'(m_zero));
        if (m_valid) chk({tag, "_code"}, 32'(code), 32'(m_code));
    endtask

    task automatic step(input string tag, input logic [7:0] r,
                        input logic l, input logic rdy);
        req       = r;
        load      = l;
        out_ready = rdy;
        @(posedge clk);
        model_step(r, l, rdy);
        #1;
        compare(tag);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_code"}, 32'(code), 0);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_zero"}, 32'(zero), 0);
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        load      = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // lowest-first drain of 1010_0100
        step("r028a", 8'hA4, 1'b1, 1'b1);
        chk("r028_c2", 32'(code), 2);
        step("r028b", 8'h00, 1'b0, 1'b1);
        chk("r028_c5", 32'(code), 5);
        step("r028c", 8'h00, 1'b0, 1'b1);
        chk("r028_c7", 32'(code), 7);
        step("r028d", 8'h00, 1'b0, 1'b1);
        chk("r028_idle", 32'(busy), 0);

        // empty load pulses zero once
        step("r029a", 8'h00, 1'b1, 1'b0);
        chk("r029_zero", 32'(zero), 1);
        step("r029b", 8'h00, 1'b0, 1'b0);
        chk("r029_zero_end", 32'(zero), 0);

        // back-pressure holds code
        step("r030a", 8'h81, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("r030h", 8'h00, 1'b0, 1'b0);
            chk("r030_hold", 32'(code), 0);
        end
        step("r030b", 8'h00, 1'b0, 1'b1);
        chk("r030_c7", 32'(code), 7);
        step("r030c", 8'h00, 1'b0, 1'b1);

        // re-request on the accept cycle stays pending
        step("r031a", 8'h06, 1'b1, 1'b0);
        chk("r031_c1", 32'(code), 1);
        step("r031b", 8'h02, 1'b1, 1'b1);
`ifdef ENC_RR_EN
        chk("r031_rr2", 32'(code), 2);
`else
        chk("r031_fx1", 32'(code), 1);
`endif
        step("r031c", 8'h00, 1'b0, 1'b1);
`ifdef ENC_RR_EN
        chk("r031_rr1", 32'(code), 1);
`else
        chk("r031_fx2", 32'(code), 2);
`endif
        step("r031d", 8'h00, 1'b0, 1'b1);

        // pointer wrap after serving index 4
        step("r032a", 8'h10, 1'b1, 1'b0);
        chk("r032_c4", 32'(code), 4);
        step("r032b", 8'h00, 1'b0, 1'b1);
        step("r032c", 8'h11, 1'b1, 1'b0);
        chk("r032_c0", 32'(code), 0);
        step("r032d", 8'h00, 1'b0, 1'b1);
        chk("r032_c4b", 32'(code), 4);
        step("r032e", 8'h00, 1'b0, 1'b1);

        // reset mid-serve discards everything
        step("r033a", 8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step("r033s", 8'h00, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check_all_zero("r033_rst");
        model_reset();
        #1;
        rst = 1'b0;
        step("r033b", 8'h08, 1'b1, 1'b0);
        chk("r033_c3", 32'(code), 3);
        step("r033c", 8'h00, 1'b0, 1'b1);
        chk("r033_idle", 32'(out_valid), 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [7:0] r;
            r = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            step("rand", r, 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
